// File: rtl/ext_bus_pkg.sv
// Shared state encoding, width helpers and counter sizing for the external-bus sequencer.
package ext_bus_pkg;

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DONE} state_t;

   localparam int WCNT_W = 3;

   function automatic int nb_of(input int dw);
      return dw / 8;
   endfunction

   function automatic int lb_of(input int dw);
      return $clog2(dw / 8);
   endfunction

   function automatic int iw_of(input int dw);
      return (lb_of(dw) > 0) ? lb_of(dw) : 1;
   endfunction

   function automatic int ab_of(input int aw);
      return aw / 8;
   endfunction

endpackage

// File: rtl/ext_bus_lane_sel.sv
// Combinational next-enabled-lane finder: lowest set mask bit above cur (or from lane 0 when start).
module ext_bus_lane_sel #(
   parameter int NB = 2,
   parameter int IW = 1
) (
   input  logic [NB-1:0] mask,
   input  logic [IW-1:0] cur,
   input  logic          start,
   output logic [IW-1:0] nxt,
   output logic          last
);

   // Descending scan so the lowest qualifying lane wins; last means nothing follows cur.
   always_comb begin
      nxt  = '0;
      last = 1'b1;
      for (int l = NB - 1; l >= 0; l--) begin
         if (mask[l] && (start || (l > int'(cur)))) begin
            nxt  = IW'(l);
            last = 1'b0;
         end
      end
   end

endmodule

// File: rtl/ext_bus_seq.sv
// External-bus sequencer: serialises CPU read/write ports onto an 8-bit multiplexed pin bus.
// Define EXTBUS_READY_EN to let pin_ready stretch each data-lane phase.
module ext_bus_seq
   import ext_bus_pkg::*;
#(
   parameter int DW          = 16,
   parameter int AW          = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                     clk,
   input  logic                     reset_in,
   input  logic                     ena,
   input  logic [AW-lb_of(DW)-1:0]  raddr,
   input  logic                     rreq,
   output logic [DW-1:0]            rdata,
   output logic                     rdone,
   input  logic [AW-lb_of(DW)-1:0]  waddr,
   input  logic [DW-1:0]            wdata,
   input  logic [nb_of(DW)-1:0]     wmask,
   output logic                     wdone,
   output logic [7:0]               pin_out,
   input  logic [7:0]               pin_in,
   output logic [ab_of(AW)-1:0]     pin_latch,
   output logic                     pin_wr,
   output logic                     pin_rd,
   output logic [iw_of(DW)-1:0]     pin_idx,
   input  logic                     pin_ready
);

   localparam int NB  = nb_of(DW);
   localparam int LB  = lb_of(DW);
   localparam int IW  = iw_of(DW);
   localparam int AB  = ab_of(AW);
   localparam int ABW = (AB > 1) ? $clog2(AB) : 1;

   state_t            state;
   logic [AW-1:0]     addr_q;
   logic [DW-1:0]     dat_q;
   logic [NB-1:0]     msk_q;
   logic              is_wr;
   logic [ABW-1:0]    abyte;
   logic [ABW-1:0]    ab_nxt;
   logic [IW-1:0]     lane;
   logic [WCNT_W-1:0] wcnt;
   logic [AW-1:0]     waddr_b;
   logic [AW-1:0]     raddr_b;
   logic [NB-1:0]     sel_mask;
   logic              sel_start;
   logic [IW-1:0]     sel_lane;
   logic              sel_last;
   logic              at_wait;
   logic              rdy;

`ifdef EXTBUS_READY_EN
   assign rdy = pin_ready;
`else
   logic unused_ready;
   assign unused_ready = pin_ready;
   assign rdy          = 1'b1;
`endif

   // Word addresses become byte addresses with the lane bits forced to zero.
   assign waddr_b   = AW'(waddr) << LB;
   assign raddr_b   = AW'(raddr) << LB;
   assign ab_nxt    = abyte - 1'b1;
   assign at_wait   = (wcnt == WCNT_W'(WAIT_CYCLES));
   assign sel_mask  = is_wr ? msk_q : '1;
   assign sel_start = (state == ADDR);

   ext_bus_lane_sel #(
      .NB (NB),
      .IW (IW)
   ) u_lane_sel (
      .mask  (sel_mask),
      .cur   (lane),
      .start (sel_start),
      .nxt   (sel_lane),
      .last  (sel_last)
   );

   always_ff @(posedge clk) begin
      if (reset_in) begin
         state     <= IDLE;
         pin_out   <= '0;
         pin_latch <= '0;
         pin_wr    <= 1'b0;
         pin_rd    <= 1'b0;
         pin_idx   <= '0;
         rdone     <= 1'b0;
         wdone     <= 1'b0;
         rdata     <= '0;
         is_wr     <= 1'b0;
         abyte     <= '0;
         lane      <= '0;
         wcnt      <= '0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (|wmask) begin
                  addr_q    <= waddr_b;
                  dat_q     <= wdata;
                  msk_q     <= wmask;
                  is_wr     <= 1'b1;
                  abyte     <= ABW'(AB - 1);
                  pin_latch <= AB'(1) << (AB - 1);
                  pin_out   <= waddr_b[AW-1 -: 8];
                  state     <= ADDR;
               end else if (rreq) begin
                  addr_q    <= raddr_b;
                  is_wr     <= 1'b0;
                  abyte     <= ABW'(AB - 1);
                  pin_latch <= AB'(1) << (AB - 1);
                  pin_out   <= raddr_b[AW-1 -: 8];
                  state     <= ADDR;
               end
            end
            ADDR: begin
               if (abyte != '0) begin
                  abyte     <= ab_nxt;
                  pin_latch <= AB'(1) << ab_nxt;
                  pin_out   <= addr_q[8*ab_nxt +: 8];
               end else begin
                  pin_latch <= '0;
                  lane      <= sel_lane;
                  pin_idx   <= sel_lane;
                  wcnt      <= '0;
                  if (is_wr) begin
                     pin_wr  <= 1'b1;
                     pin_out <= dat_q[8*sel_lane +: 8];
                     state   <= WDATA;
                  end else begin
                     pin_rd  <= 1'b1;
                     state   <= RDATA;
                  end
               end
            end
            WDATA, RDATA: begin
               if (!at_wait) begin
                  wcnt <= wcnt + 1'b1;
               end else if (rdy) begin
                  if (state == RDATA) rdata[8*lane +: 8] <= pin_in;
                  if (sel_last) begin
                     pin_wr <= 1'b0;
                     pin_rd <= 1'b0;
                     wdone  <= is_wr;
                     rdone  <= !is_wr;
                     state  <= DONE;
                  end else begin
                     lane    <= sel_lane;
                     pin_idx <= sel_lane;
                     wcnt    <= '0;
                     if (is_wr) pin_out <= dat_q[8*sel_lane +: 8];
                  end
               end
            end
            DONE: begin
               wdone <= 1'b0;
               rdone <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ext_bus_seq.sv
// Scoreboard bench for ext_bus_seq: three configurations, expected bus events queued per instance.
module tb_ext_bus_seq;

   typedef struct packed {
      logic [7:0]  t;
      logic [3:0]  kind;
      logic [7:0]  sel;
      logic [7:0]  data;
      logic [31:0] rd;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;
   bit mon_en = 1'b0;
   int start_a = 0, start_b = 0, start_c = 0;
   ev_t q_a[$];
   ev_t q_b[$];
   ev_t q_c[$];

   // Instance A: DW=16, AW=16, no waits
   logic        rst_a, rreq_a, rdone_a, wdone_a, pin_wr_a, pin_rd_a, rdy_a;
   logic [14:0] raddr_a, waddr_a;
   logic [15:0] rdata_a, wdata_a;
   logic [1:0]  wmask_a, pin_latch_a;
   logic [7:0]  pin_out_a, pin_in_a;
   logic [0:0]  pin_idx_a;
   assign pin_in_a = !rdy_a ? 8'hEE : (pin_idx_a == 1'b0) ? 8'h5A : 8'hC3;

   ext_bus_seq #(.DW(16), .AW(16), .WAIT_CYCLES(0)) u_a (
      .clk(clk), .reset_in(rst_a), .ena(1'b1), .raddr(raddr_a), .rreq(rreq_a),
      .rdata(rdata_a), .rdone(rdone_a), .waddr(waddr_a), .wdata(wdata_a),
      .wmask(wmask_a), .wdone(wdone_a), .pin_out(pin_out_a), .pin_in(pin_in_a),
      .pin_latch(pin_latch_a), .pin_wr(pin_wr_a), .pin_rd(pin_rd_a),
      .pin_idx(pin_idx_a), .pin_ready(rdy_a));

   // Instance B: DW=16, AW=16, two wait states
   logic        rst_b, rreq_b, rdone_b, wdone_b, pin_wr_b, pin_rd_b;
   logic [14:0] raddr_b, waddr_b;
   logic [15:0] rdata_b, wdata_b;
   logic [1:0]  wmask_b, pin_latch_b;
   logic [7:0]  pin_out_b, pin_in_b;
   logic [0:0]  pin_idx_b;
   assign pin_in_b = (pin_idx_b == 1'b0) ? 8'hCD : 8'hAB;

   ext_bus_seq #(.DW(16), .AW(16), .WAIT_CYCLES(2)) u_b (
      .clk(clk), .reset_in(rst_b), .ena(1'b1), .raddr(raddr_b), .rreq(rreq_b),
      .rdata(rdata_b), .rdone(rdone_b), .waddr(waddr_b), .wdata(wdata_b),
      .wmask(wmask_b), .wdone(wdone_b), .pin_out(pin_out_b), .pin_in(pin_in_b),
      .pin_latch(pin_latch_b), .pin_wr(pin_wr_b), .pin_rd(pin_rd_b),
      .pin_idx(pin_idx_b), .pin_ready(1'b1));

   // Instance C: DW=32, AW=16, no waits, ena exercised
   logic        rst_c, ena_c, rreq_c, rdone_c, wdone_c, pin_wr_c, pin_rd_c;
   logic [13:0] raddr_c, waddr_c;
   logic [31:0] rdata_c, wdata_c;
   logic [3:0]  wmask_c;
   logic [1:0]  pin_latch_c, pin_idx_c;
   logic [7:0]  pin_out_c;

   ext_bus_seq #(.DW(32), .AW(16), .WAIT_CYCLES(0)) u_c (
      .clk(clk), .reset_in(rst_c), .ena(ena_c), .raddr(raddr_c), .rreq(rreq_c),
      .rdata(rdata_c), .rdone(rdone_c), .waddr(waddr_c), .wdata(wdata_c),
      .wmask(wmask_c), .wdone(wdone_c), .pin_out(pin_out_c), .pin_in(8'h00),
      .pin_latch(pin_latch_c), .pin_wr(pin_wr_c), .pin_rd(pin_rd_c),
      .pin_idx(pin_idx_c), .pin_ready(1'b1));

   function automatic ev_t mk_ev(input int t, input logic la, input logic [7:0] lat,
                                 input logic wr, input logic rd, input logic [7:0] idx,
                                 input logic wd, input logic rdn, input logic [7:0] out,
                                 input logic [31:0] rdat);
      ev_t e;
      int  n;
      n      = int'(la) + int'(wr) + int'(rd) + int'(wd) + int'(rdn);
      e.t    = 8'(t);
      e.data = out;
      e.rd   = rdat;
      e.sel  = 8'h00;
      e.kind = 4'd0;
      if (n > 1)     e.kind = 4'd15;
      else if (la)   begin e.kind = 4'd1; e.sel = lat; end
      else if (wr)   begin e.kind = 4'd2; e.sel = idx; end
      else if (rd)   begin e.kind = 4'd3; e.sel = idx; end
      else if (wd)   e.kind = 4'd4;
      else if (rdn)  e.kind = 4'd5;
      return e;
   endfunction

   task automatic ex(input int d, input int t, input int k, input int sel,
                     input int out, input int rd);
      ev_t e;
      e.t    = 8'(t);
      e.kind = 4'(k);
      e.sel  = 8'(sel);
      e.data = 8'(out);
      e.rd   = 32'(rd);
      case (d)
         0:       q_a.push_back(e);
         1:       q_b.push_back(e);
         default: q_c.push_back(e);
      endcase
   endtask

   task automatic check_ev(input int d, input ev_t g);
      ev_t e;
      int  sz;
      checks++;
      sz = (d == 0) ? q_a.size() : (d == 1) ? q_b.size() : q_c.size();
      if (sz == 0) begin
         $display("FAIL dut%0d unexpected event got t=%0d k=%0d sel=%h out=%h rdata=%h required none",
                  d, g.t, g.kind, g.sel, g.data, g.rd);
         return;
      end
      case (d)
         0:       e = q_a.pop_front();
         1:       e = q_b.pop_front();
         default: e = q_c.pop_front();
      endcase
      if (g === e) passes++;
      else $display("FAIL dut%0d event got t=%0d k=%0d sel=%h out=%h rdata=%h required t=%0d k=%0d sel=%h out=%h rdata=%h",
                    d, g.t, g.kind, g.sel, g.data, g.rd, e.t, e.kind, e.sel, e.data, e.rd);
   endtask

   task automatic check_val(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s got %h required %h", nm, got, exp);
   endtask

   always @(negedge clk) begin : mon_a
      ev_t g;
      if (mon_en) begin
         g = mk_ev(cyc - start_a, |pin_latch_a, 8'(pin_latch_a), pin_wr_a, pin_rd_a,
                   8'(pin_idx_a), wdone_a, rdone_a, pin_out_a, 32'(rdata_a));
         if (g.kind != 4'd0) check_ev(0, g);
      end
   end

   always @(negedge clk) begin : mon_b
      ev_t g;
      if (mon_en) begin
         g = mk_ev(cyc - start_b, |pin_latch_b, 8'(pin_latch_b), pin_wr_b, pin_rd_b,
                   8'(pin_idx_b), wdone_b, rdone_b, pin_out_b, 32'(rdata_b));
         if (g.kind != 4'd0) check_ev(1, g);
      end
   end

   always @(negedge clk) begin : mon_c
      ev_t g;
      if (mon_en) begin
         g = mk_ev(cyc - start_c, |pin_latch_c, 8'(pin_latch_c), pin_wr_c, pin_rd_c,
                   8'(pin_idx_c), wdone_c, rdone_c, pin_out_c, rdata_c);
         if (g.kind != 4'd0) check_ev(2, g);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int d, input bit rd);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         case (d)
            0:       seen = rd ? rdone_a : wdone_a;
            1:       seen = rd ? rdone_b : wdone_b;
            default: seen = rd ? rdone_c : wdone_c;
         endcase
         if (seen) begin
            case (d)
               0:       if (rd) rreq_a = 1'b0; else wmask_a = '0;
               1:       if (rd) rreq_b = 1'b0; else wmask_b = '0;
               default: if (rd) rreq_c = 1'b0; else wmask_c = '0;
            endcase
         end
      end
      checks++;
      if (seen) passes++;
      else $display("FAIL dut%0d done_wait got timeout required %s pulse", d, rd ? "rdone" : "wdone");
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got hang required finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; ena_c = 1'b1; rdy_a = 1'b1;
      rreq_a = 1'b0; rreq_b = 1'b0; rreq_c = 1'b0;
      raddr_a = '0; raddr_b = '0; raddr_c = '0;
      waddr_a = '0; waddr_b = '0; waddr_c = '0;
      wdata_a = '0; wdata_b = '0; wdata_c = '0;
      wmask_a = '0; wmask_b = '0; wmask_c = '0;
      tick(); tick();
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      tick();
      check_val("reset_a", 64'({pin_out_a, pin_latch_a, pin_wr_a, pin_rd_a, pin_idx_a, wdone_a, rdone_a, rdata_a}), 64'h0);
      check_val("reset_b", 64'({pin_out_b, pin_latch_b, pin_wr_b, pin_rd_b, pin_idx_b, wdone_b, rdone_b, rdata_b}), 64'h0);
      check_val("reset_c", 64'({pin_out_c, pin_latch_c, pin_wr_c, pin_rd_c, pin_idx_c, wdone_c, rdone_c, rdata_c}), 64'h0);
      mon_en = 1'b1;

      // Full write on A: 0x1234 <- 0xBEEF
      ex(0, 1, 1, 2, 'h12, 0); ex(0, 2, 1, 1, 'h34, 0);
      ex(0, 3, 2, 0, 'hEF, 0); ex(0, 4, 2, 1, 'hBE, 0); ex(0, 5, 4, 0, 'hBE, 0);
      start_a = cyc; waddr_a = 15'h091A; wdata_a = 16'hBEEF; wmask_a = 2'b11;
      wait_done(0, 1'b0);
      tick(); tick(); tick();

      // Read with two wait states on B: 0x8000 -> 0xABCD
      ex(1, 1, 1, 2, 'h80, 0); ex(1, 2, 1, 1, 'h00, 0);
      for (int t = 3; t <= 5; t++) ex(1, t, 3, 0, 'h00, 0);
      for (int t = 6; t <= 8; t++) ex(1, t, 3, 1, 'h00, 'hCD);
      ex(1, 9, 5, 0, 'h00, 'hABCD);
      start_b = cyc; raddr_b = 15'h4000; rreq_b = 1'b1;
      wait_done(1, 1'b1);
      tick(); tick(); tick();

      // Sparse write on C with a two-cycle ena stall during lane 0
      ex(2, 1, 1, 2, 'hA5, 0); ex(2, 2, 1, 1, 'hC0, 0);
      for (int t = 3; t <= 5; t++) ex(2, t, 2, 0, 'h11, 0);
      ex(2, 6, 2, 2, 'h33, 0); ex(2, 7, 4, 0, 'h33, 0);
      start_c = cyc; waddr_c = 14'h2970; wdata_c = 32'h44332211; wmask_c = 4'b0101;
      tick(); tick(); tick();
      ena_c = 1'b0;
      tick(); tick();
      ena_c = 1'b1;
      wait_done(2, 1'b0);
      tick(); tick(); tick();

      // Simultaneous write and read on A: write first, read follows
      ex(0, 1, 1, 2, 'h10, 0); ex(0, 2, 1, 1, 'h00, 0);
      ex(0, 3, 2, 1, 'h77, 0); ex(0, 4, 4, 0, 'h77, 0);
      ex(0, 6, 1, 2, 'h02, 0); ex(0, 7, 1, 1, 'h46, 0);
      ex(0, 8, 3, 0, 'h46, 0); ex(0, 9, 3, 1, 'h46, 'h005A);
      ex(0, 10, 5, 0, 'h46, 'hC35A);
      start_a = cyc; waddr_a = 15'h0800; wdata_a = 16'h7788; wmask_a = 2'b10;
      raddr_a = 15'h0123; rreq_a = 1'b1;
      wait_done(0, 1'b0);
      wait_done(0, 1'b1);
      tick(); tick(); tick();

      // Reset mid-read on A, then the same read served normally
      ex(0, 1, 1, 2, 'h0F, 'hC35A); ex(0, 2, 1, 1, 'h00, 'hC35A); ex(0, 3, 3, 0, 'h00, 'hC35A);
      start_a = cyc; raddr_a = 15'h0780; rreq_a = 1'b1;
      tick(); tick(); tick();
      rst_a = 1'b1; rreq_a = 1'b0;
      tick();
      rst_a = 1'b0;
      check_val("abort_a", 64'({pin_latch_a, pin_wr_a, pin_rd_a, wdone_a, rdone_a, rdata_a}), 64'h0);
      tick(); tick();
      ex(0, 1, 1, 2, 'h0F, 0); ex(0, 2, 1, 1, 'h00, 0); ex(0, 3, 3, 0, 'h00, 0);
      ex(0, 4, 3, 1, 'h00, 'h5A); ex(0, 5, 5, 0, 'h00, 'hC35A);
      start_a = cyc; rreq_a = 1'b1;
      wait_done(0, 1'b1);
      tick(); tick(); tick();

`ifdef EXTBUS_READY_EN
      // pin_ready low for four cycles on lane 0 of a read on A
      ex(0, 1, 1, 2, 'h0F, 'hC35A); ex(0, 2, 1, 1, 'h00, 'hC35A);
      for (int t = 3; t <= 7; t++) ex(0, t, 3, 0, 'h00, 'hC35A);
      ex(0, 8, 3, 1, 'h00, 'hC35A); ex(0, 9, 5, 0, 'h00, 'hC35A);
      start_a = cyc; rreq_a = 1'b1;
      tick(); tick(); tick();
      rdy_a = 1'b0;
      tick(); tick(); tick(); tick();
      rdy_a = 1'b1;
      wait_done(0, 1'b1);
      tick(); tick(); tick();
`endif

      tick(); tick();
      check_val("queue_a_empty", 64'(q_a.size()), 64'h0);
      check_val("queue_b_empty", 64'(q_b.size()), 64'h0);
      check_val("queue_c_empty", 64'(q_c.size()), 64'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
